spart_tx: RTL

//  Transmit half of the SPART serial port: accepts a byte from the processor bus, serialises it as an 8N1 frame on txd.

---
 rtl/spart_pkg.sv | 16 +
 rtl/spart_tx.sv | 118 +++++++++++
 2 files changed

// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types and register map
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [1:0] ADDR_TXRX   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

endpackage

// File: rtl/spart_tx.sv
// rtl/spart_tx.sv - SPART transmitter: one-byte holding buffer feeding an 8N1 serialiser
module spart_tx
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 enable,
  output logic                 txd,
  output logic                 tbr,
  output logic                 tx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] holding;
  logic [DATA_BITS-1:0] shift;
  logic                 wr;
  logic                 bit_end;
  logic                 load;

  // Bus decode, end-of-bit detect, and the moment the holding byte moves into the shifter
  always_comb begin
    wr      = iocs & ~iorw & (ioaddr == ADDR_TXRX);
    bit_end = enable & (state != IDLE) & (tick_cnt == TICK_LAST);
    load    = ~tbr & (((state == IDLE) & enable) | ((state == STOP) & bit_end));
  end

  // Holding register: filled by a bus write while empty, emptied when the shifter takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holding <= '0;
      tbr     <= 1'b1;
    end else if (load) begin
      tbr <= 1'b1;
    end else if (wr && tbr) begin
      holding <= tx_data;
      tbr     <= 1'b0;
    end
  end

  // Oversample tick counter; runs only while a frame is on the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (load) begin
      tick_cnt <= '0;
    end else if (enable && state != IDLE) begin
      tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
    end
  end

  // Frame sequencer: drives txd from registers so the line never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx_busy <= 1'b0;
      txd     <= 1'b1;
      bit_idx <= '0;
      shift   <= '0;
    end else if (load) begin
      shift   <= holding;
      txd     <= 1'b0;
      state   <= START;
      tx_busy <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            txd     <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            txd     <= 1'b1;
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          tx_busy <= 1'b0;
          txd     <= 1'b1;
        end
      endcase
    end
  end

endmodule
